// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the burst read responder.
package mem_resp_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned WORD_AW   = ADDR_W - 1;
  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned BEAT_W    = 3;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } state_t;

  // Word address of beat k: block bits fixed, offset wraps inside the 8-word block.
  function automatic logic [WORD_AW-1:0] beat_word_addr(input logic [WORD_AW-1:0] base,
                                                        input logic [BEAT_W-1:0]  beat);
    logic [BEAT_W-1:0] off;
    off = base[BEAT_W-1:0] + beat;
    return {base[WORD_AW-1:BEAT_W], off};
  endfunction

endpackage

// File: rtl/mem_burst_responder_mem_array.sv
// Word storage: synchronous write, combinational read, contents survive reset.
module mem_array #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_burst_responder.sv
// Single-port memory responder: immediate writes, fixed-latency single or
// critical-word-first wrapped 8-beat burst reads.
module mem_burst_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [BEAT_W-1:0] rsp_beat,
  output logic              rsp_last
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORD_AW-1:0] r_addr;
  logic               r_burst;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_last;

  logic               w_wr_accept;
  logic               w_rd_accept;
  logic [WORD_AW-1:0] w_raddr;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_unused_addr_lsb;

  // Byte address bit 0 never selects anything in a 16-bit word array.
  assign w_unused_addr_lsb = req_addr[0];

  assign w_wr_accept = req_valid & r_req_ready & req_wr;
  assign w_rd_accept = req_valid & r_req_ready & ~req_wr;
  assign w_raddr     = beat_word_addr(r_addr, r_beat);

  mem_array #(
    .AW (WORD_AW),
    .DW (DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_accept),
    .i_waddr (req_addr[ADDR_W-1:1]),
    .i_wdata (req_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Request/response FSM with latency and beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_burst     <= 1'b0;
      r_beat      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_accept) begin
            r_addr      <= req_addr[ADDR_W-1:1];
            r_burst     <= req_burst;
            r_cnt       <= CNT_W'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= BEAT;
            r_beat      <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= ~r_burst;
          end
        end
        BEAT: begin
          if (r_rsp_last) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_req_ready <= 1'b1;
          end else begin
            r_beat     <= r_beat + BEAT_W'(1);
            r_rsp_last <= (r_beat == BEAT_W'(BURST_LEN - 2));
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_beat      <= '0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_last  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_beat  = r_beat;
  assign rsp_last  = r_rsp_last;
  // Array read is combinational; gated so idle and reset present zero data.
  assign rsp_rdata = r_rsp_valid ? w_rdata : '0;

endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to the first response beat; legal range 2..15.
REQ-002 SHALL have parameter BURST_LEN, default 8: beats per burst read; fixed at 8 (16-byte block).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: responder can accept; a transfer occurs on a rising edge with req_valid & req_ready.
REQ-007 SHALL have port req_wr, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port req_burst, input, 1: read only; 1 = 8-beat block read, 0 = single-word read; ignored on writes.
REQ-009 SHALL have port req_addr, input, 16: byte address; bit 0 ignored.
REQ-010 SHALL have port req_wdata, input, 16: write data.
REQ-011 SHALL have port rsp_valid, output, 1: rsp_rdata is valid this cycle; there is no backpressure.
REQ-012 SHALL have port rsp_rdata, output, 16: read data.
REQ-013 SHALL have port rsp_beat, output, 3: beat index 0..7 within the current response.
REQ-014 SHALL have port rsp_last, output, 1: final beat of the current response.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, and BEAT.
- req_ready = 1 only in IDLE.
REQ-016 SHALL commit an accepted write to the array at its acceptance edge.
- FSM stays in IDLE; no response is produced; a next request may be accepted on the following cycle.
REQ-017 SHALL, on an accepted read, latch the address and burst flag, load a latency counter with LATENCY-1, and enter WAIT.
REQ-018 SHALL decrement the counter once per cycle in WAIT and enter BEAT when it reaches 0.
- For acceptance in cycle T, the first rsp_valid = 1 occurs in cycle T+LATENCY.
REQ-019 SHALL, in BEAT, assert rsp_valid for exactly 1 beat (single read) or 8 consecutive beats (burst), then return to IDLE.
- req_ready = 1 in the cycle after the last beat.
REQ-020 SHALL order burst beats critical-word first with wrap-around.
- Beat k address: {addr[15:4], (addr[3:1]+k) mod 8, 1'b0}.
- addr[15:4] never changes during a burst.
REQ-021 SHALL read rsp_rdata from the array combinationally at the current beat address; no writes can occur while busy, so the data is coherent.
REQ-022 SHALL drive rsp_beat = k on beat k.
- rsp_beat = 0 on single reads.
- rsp_beat = 0 when rsp_valid = 0.
REQ-023 SHALL assert rsp_last on beat 7 of a burst and on the only beat of a single read; rsp_last = 0 otherwise.
REQ-024 SHALL ignore req_valid while not in IDLE: no state change, no array write.
REQ-025 SHALL have storage of 32K x 16 words, indexed by addr[15:1].

Reset
REQ-026 SHALL, while rst_n = 0 (asynchronous assert), force: state = IDLE, counter = 0, req_ready = 1, rsp_valid = 0, rsp_last = 0, rsp_beat = 0, rsp_rdata = 0.
REQ-027 SHALL abort any in-flight read when reset is asserted mid-operation; no further beats follow after deassertion.
REQ-028 SHALL NOT clear or alter array contents on reset.
REQ-029 SHALL allow the first request to be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place the state enum (IDLE/WAIT/BEAT), BURST_LEN = 8, and ADDR_W = 16 in shared package mem_resp_pkg.
REQ-031 SHALL isolate the storage in one sub-module, mem_array: 32K x 16, one synchronous write port, one combinational read port, no reset.
REQ-032 SHALL keep the FSM, latency counter, and beat counter in mem_burst_responder.

Verification
REQ-033 SHALL cover a write then a single read:
- Stimulus: write 0xBEEF to 0x0010, then single read of 0x0010 accepted in cycle T.
- Response: rsp_valid only in cycle T+4, rsp_rdata = 0xBEEF, rsp_beat = 0, rsp_last = 1.
REQ-034 SHALL cover a wrapped burst:
- Stimulus: preload 0x1230..0x123E with 0xA000+index, then burst read at 0x123A.
- Response: 8 beats of data 0xA005, 0xA006, 0xA007, 0xA000..0xA004; rsp_beat 0..7; rsp_last only on beat 7.
REQ-035 SHALL cover requests while busy:
- Stimulus: hold req_valid = 1 with write 0x5555 to 0x0020 throughout a burst.
- Response: req_ready = 0 from acceptance until after the last beat; write commits only once back in IDLE; 0x0020 reads 0x5555 afterward.
REQ-036 SHALL cover reset mid-burst:
- Stimulus: assert rst_n = 0 during beat 3.
- Response: rsp_valid drops immediately; after release there are no beats and req_ready = 1; array contents are unchanged.
REQ-037 SHALL cover back-to-back writes:
- Stimulus: writes on consecutive cycles to 0x0000 and 0x0002.
- Response: both commit with no stall; readback returns both values.
REQ-038 SHALL cover the odd-address case:
- Stimulus: write 0x1111 to 0x0041.
- Response: a read of 0x0040 returns 0x1111.
